// File: rtl/fixed_point_pkg.sv
// Shared fixed-point helpers: default widths plus pure saturate and
// round-half-up shift functions that operate on a common 64-bit signed
// working width. Callers sign-extend into FN_W and slice the result back.
package fixed_point_pkg;

  localparam int FN_W                = 64;
  localparam int DEF_WORD_WIDTH_IN_1 = 16;
  localparam int DEF_WORD_WIDTH_IN_2 = 16;
  localparam int PROD_WIDTH          = DEF_WORD_WIDTH_IN_1 + DEF_WORD_WIDTH_IN_2;

  localparam logic [FN_W-1:0] ONE_W = {{(FN_W-1){1'b0}}, 1'b1};

  // Clamp a signed value into the two's complement range of 'width' bits.
  function automatic logic signed [FN_W-1:0] sat_signed(
    input logic signed [FN_W-1:0] value,
    input int                     width
  );
    logic signed [FN_W-1:0] max_v;
    logic signed [FN_W-1:0] min_v;
    logic signed [FN_W-1:0] res;
    max_v = $signed((ONE_W << (width - 1)) - ONE_W);
    min_v = ~max_v;
    res   = value;
    if (value > max_v) begin
      res = max_v;
    end else if (value < min_v) begin
      res = min_v;
    end
    return res;
  endfunction

  // Arithmetic right shift with round-half-up (add half an LSB first).
  function automatic logic signed [FN_W-1:0] round_shift(
    input logic signed [FN_W-1:0] value,
    input int                     shift
  );
    logic signed [FN_W-1:0] v;
    v = value;
    if (shift > 0) begin
      v = v + $signed(ONE_W << (shift - 1));
    end
    return v >>> shift;
  endfunction

endpackage

// File: rtl/baugh_wooley_mult.sv
// Combinational two's complement multiplier using the Baugh-Wooley scheme:
// partial products that involve exactly one sign bit are inverted and a
// fixed correction constant is added, so the whole array is unsigned adds.
module baugh_wooley_mult #(
  parameter int WIDTH_A = 16,
  parameter int WIDTH_B = 16
) (
  input  logic [WIDTH_A-1:0]         a_i,
  input  logic [WIDTH_B-1:0]         b_i,
  output logic [WIDTH_A+WIDTH_B-1:0] product_o
);

  localparam int PW = WIDTH_A + WIDTH_B;

  logic [PW-1:0] sum_v;
  logic          pp;

  // Sum all partial products, then add 2^(PW-1) + 2^(A-1) + 2^(B-1).
  always_comb begin
    sum_v = '0;
    pp    = 1'b0;
    for (int i = 0; i < WIDTH_A; i++) begin
      for (int j = 0; j < WIDTH_B; j++) begin
        pp = a_i[i] & b_i[j];
        if ((i == WIDTH_A - 1) != (j == WIDTH_B - 1)) begin
          pp = ~pp;
        end
        sum_v = sum_v + (PW'(pp) << (i + j));
      end
    end
    sum_v = sum_v + (PW'(1) << (PW - 1)) + (PW'(1) << (WIDTH_A - 1))
                  + (PW'(1) << (WIDTH_B - 1));
    product_o = sum_v;
  end

endmodule

// File: rtl/fixed_point_mac_pipe_round_sat.sv
// Output-stage arithmetic: round-half-up binary-point shift followed by a
// clamp to the output width. clamp_o flags that the value did not fit.
module fixed_point_round_sat
  import fixed_point_pkg::*;
#(
  parameter int IN_W  = 41,
  parameter int OUT_W = 16,
  parameter int SHIFT = 8
) (
  input  logic [IN_W-1:0]  value_i,
  output logic [OUT_W-1:0] result_o,
  output logic             clamp_o
);

  logic signed [FN_W-1:0] wide;
  logic signed [FN_W-1:0] shifted;
  logic signed [FN_W-1:0] sat;

  // Widen, shift with rounding, then clamp and detect clamping.
  always_comb begin
    wide     = {{(FN_W-IN_W){value_i[IN_W-1]}}, value_i};
    shifted  = round_shift(wide, SHIFT);
    sat      = sat_signed(shifted, OUT_W);
    result_o = sat[OUT_W-1:0];
    clamp_o  = (sat != shifted);
  end

endmodule

// File: rtl/fixed_point_mac_pipe.sv
// Three-stage signed fixed-point multiply/accumulate with valid/ready flow
// control. S1 holds operands, S2 the full product, S3 the rounded and
// saturated result. Non-last accumulate beats fold into the accumulator
// straight out of S2 and never occupy S3. ACC_WIDTH+1 must stay below the
// 64-bit working width of the package helpers.
module fixed_point_mac_pipe
  import fixed_point_pkg::*;
#(
  parameter int WORD_WIDTH_IN_1 = DEF_WORD_WIDTH_IN_1,
  parameter int WORD_WIDTH_IN_2 = DEF_WORD_WIDTH_IN_2,
  parameter int WORD_WIDTH_OUT  = 16,
  parameter int FRAC_SHIFT      = 8,
  parameter int ACC_WIDTH       = PROD_WIDTH + 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_WIDTH_IN_1-1:0] multiplier,
  input  logic [WORD_WIDTH_IN_2-1:0] multiplicand,
  input  logic                       in_acc_mode,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_WIDTH_OUT-1:0]  result,
  output logic                       out_overflow
);

  localparam int PROD_W = WORD_WIDTH_IN_1 + WORD_WIDTH_IN_2;
  localparam int EXT_W  = ACC_WIDTH + 1;

  logic                       s1_valid_q, s1_valid_d;
  logic [WORD_WIDTH_IN_1-1:0] s1_a_q, s1_a_d;
  logic [WORD_WIDTH_IN_2-1:0] s1_b_q, s1_b_d;
  logic                       s1_acc_q, s1_acc_d;
  logic                       s1_last_q, s1_last_d;

  logic                       s2_valid_q, s2_valid_d;
  logic [PROD_W-1:0]          s2_prod_q, s2_prod_d;
  logic                       s2_acc_q, s2_acc_d;
  logic                       s2_last_q, s2_last_d;

  logic                       out_valid_q, out_valid_d;
  logic [WORD_WIDTH_OUT-1:0]  result_q, result_d;
  logic                       ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]       acc_q, acc_d;
  logic                       sticky_q, sticky_d;

  logic                       s3_free, s2_nl_acc, s2_adv, s2_load, s1_adv, s1_load;
  logic [PROD_W-1:0]          prod_w;
  logic [EXT_W-1:0]           acc_ext, prod_ext, sum_ext, rs_in;
  logic signed [FN_W-1:0]     sum_wide, sat_wide;
  logic                       acc_clamp;
  logic [WORD_WIDTH_OUT-1:0]  rs_result;
  logic                       rs_clamp;

  baugh_wooley_mult #(
    .WIDTH_A (WORD_WIDTH_IN_1),
    .WIDTH_B (WORD_WIDTH_IN_2)
  ) u_mult (
    .a_i       (s1_a_q),
    .b_i       (s1_b_q),
    .product_o (prod_w)
  );

  fixed_point_round_sat #(
    .IN_W  (EXT_W),
    .OUT_W (WORD_WIDTH_OUT),
    .SHIFT (FRAC_SHIFT)
  ) u_round_sat (
    .value_i  (rs_in),
    .result_o (rs_result),
    .clamp_o  (rs_clamp)
  );

  // Stage advance chain, back to front; in_ready never looks at in_valid.
  always_comb begin
    s3_free   = !out_valid_q | out_ready;
    s2_nl_acc = s2_acc_q & !s2_last_q;
    s2_adv    = s2_valid_q & (s2_nl_acc | s3_free);
    s2_load   = !s2_valid_q | s2_adv;
    s1_adv    = s1_valid_q & s2_load;
    s1_load   = !s1_valid_q | s1_adv;
  end

  // Accumulator add at ACC_WIDTH+1 bits, saturated back to ACC_WIDTH.
  always_comb begin
    acc_ext   = {acc_q[ACC_WIDTH-1], acc_q};
    prod_ext  = {{(EXT_W-PROD_W){s2_prod_q[PROD_W-1]}}, s2_prod_q};
    sum_ext   = acc_ext + prod_ext;
    sum_wide  = {{(FN_W-EXT_W){sum_ext[EXT_W-1]}}, sum_ext};
    sat_wide  = sat_signed(sum_wide, ACC_WIDTH);
    acc_clamp = (sat_wide != sum_wide);
    rs_in     = s2_acc_q ? sat_wide[EXT_W-1:0] : prod_ext;
  end

  // Next-state for all three stages and the group accumulator.
  always_comb begin
    s1_valid_d  = s1_load ? in_valid : s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_acc_d    = s1_acc_q;
    s1_last_d   = s1_last_q;
    if (s1_load && in_valid) begin
      s1_a_d    = multiplier;
      s1_b_d    = multiplicand;
      s1_acc_d  = in_acc_mode;
      s1_last_d = in_last & in_acc_mode;
    end

    s2_valid_d  = s2_load ? s1_valid_q : s2_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_acc_d    = s2_acc_q;
    s2_last_d   = s2_last_q;
    if (s2_load && s1_valid_q) begin
      s2_prod_d = prod_w;
      s2_acc_d  = s1_acc_q;
      s2_last_d = s1_last_q;
    end

    out_valid_d = out_valid_q & !out_ready;
    result_d    = result_q;
    ovf_d       = ovf_q;
    acc_d       = acc_q;
    sticky_d    = sticky_q;
    if (s2_adv) begin
      if (s2_nl_acc) begin
        acc_d    = sat_wide[ACC_WIDTH-1:0];
        sticky_d = sticky_q | acc_clamp;
      end else begin
        out_valid_d = 1'b1;
        result_d    = rs_result;
        if (s2_acc_q) begin
          ovf_d    = rs_clamp | sticky_q | acc_clamp;
          acc_d    = '0;
          sticky_d = 1'b0;
        end else begin
          ovf_d    = rs_clamp;
        end
      end
    end
  end

  // Pipeline and accumulator registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_acc_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_acc_q    <= 1'b0;
      s2_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      acc_q       <= '0;
      sticky_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_acc_q    <= s1_acc_d;
      s1_last_q   <= s1_last_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_acc_q    <= s2_acc_d;
      s2_last_q   <= s2_last_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      acc_q       <= acc_d;
      sticky_q    <= sticky_d;
    end
  end

  assign in_ready     = s1_load;
  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign out_overflow = ovf_q;

endmodule
